// File: rtl/ddr_frame_bank_ctrl.sv
// Triple-buffer frame bank manager feeding the AXI DDR3 adapter command inputs.
// The writer never touches the bank locked for reading or the latest complete bank.
//
// state        | meaning
// W_IDLE       | no frame being written
// W_ACTIVE     | frame being written into wr_bank
// R_IDLE       | ready to lock a bank for the display
// R_WAIT_BUSY  | rd_begin issued, waiting for the adapter to go busy
// R_BUSY       | adapter read in progress
module ddr_frame_bank_ctrl #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BYTES = 32'h0004_B000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_frame_start,
  input  logic                  wr_frame_done,
  input  logic                  rd_frame_req,
  input  logic                  rd_data_busy,
  output logic                  wr_begin,
  output logic [ADDR_WIDTH-1:0] wr_addr_begin,
  output logic                  rd_begin,
  output logic [ADDR_WIDTH-1:0] rd_addr_begin,
  output logic [ADDR_WIDTH-1:0] rd_addr_end,
  output logic [1:0]            wr_bank,
  output logic [1:0]            rd_bank,
  output logic [1:0]            lat_bank,
  output logic                  lat_valid,
  output logic [7:0]            wr_abort_cnt,
  output logic [7:0]            rd_miss_cnt
);

  typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT_BUSY, R_BUSY} r_state_t;

  w_state_t              w_state, w_state_nxt;
  r_state_t              r_state, r_state_nxt;
  logic                  wr_begin_nxt, rd_begin_nxt, lat_valid_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr_nxt, rd_addr_b_nxt, rd_addr_e_nxt;
  logic [1:0]            wr_bank_nxt, rd_bank_nxt, lat_bank_nxt;
  logic [7:0]            abort_nxt, miss_nxt;

  function automatic logic [ADDR_WIDTH-1:0] bank_addr(input logic [1:0] b);
    case (b)
      2'd1:    return BASE_ADDR + FRAME_BYTES;
      2'd2:    return BASE_ADDR + (FRAME_BYTES << 1);
      default: return BASE_ADDR;
    endcase
  endfunction

  function automatic logic [1:0] free_bank(input logic [1:0] rd, input logic [1:0] lat,
                                           input logic lv);
    if (rd != 2'd0 && !(lv && lat == 2'd0))      return 2'd0;
    else if (rd != 2'd1 && !(lv && lat == 2'd1)) return 2'd1;
    else                                         return 2'd2;
  endfunction

  always_comb begin
    w_state_nxt   = w_state;
    r_state_nxt   = r_state;
    wr_begin_nxt  = 1'b0;
    rd_begin_nxt  = 1'b0;
    wr_addr_nxt   = wr_addr_begin;
    rd_addr_b_nxt = rd_addr_begin;
    rd_addr_e_nxt = rd_addr_end;
    wr_bank_nxt   = wr_bank;
    rd_bank_nxt   = rd_bank;
    lat_bank_nxt  = lat_bank;
    lat_valid_nxt = lat_valid;
    abort_nxt     = wr_abort_cnt;
    miss_nxt      = rd_miss_cnt;

    // Completion is applied first so a same-cycle read or write start sees it.
    if (w_state == W_ACTIVE && wr_frame_done) begin
      lat_bank_nxt  = wr_bank;
      lat_valid_nxt = 1'b1;
      w_state_nxt   = W_IDLE;
    end

    case (r_state)
      R_IDLE: begin
        if (rd_frame_req) begin
          if (lat_valid_nxt) begin
            rd_bank_nxt   = lat_bank_nxt;
            rd_addr_b_nxt = bank_addr(lat_bank_nxt);
            rd_addr_e_nxt = bank_addr(lat_bank_nxt) + FRAME_BYTES - 1'b1;
            rd_begin_nxt  = 1'b1;
            r_state_nxt   = R_WAIT_BUSY;
          end else if (rd_miss_cnt != 8'hFF) begin
            miss_nxt = rd_miss_cnt + 8'd1;
          end
        end
      end
      R_WAIT_BUSY: begin
        if (rd_data_busy) r_state_nxt = R_BUSY;
        if (rd_frame_req && rd_miss_cnt != 8'hFF) miss_nxt = rd_miss_cnt + 8'd1;
      end
      R_BUSY: begin
        if (!rd_data_busy) r_state_nxt = R_IDLE;
        if (rd_frame_req && rd_miss_cnt != 8'hFF) miss_nxt = rd_miss_cnt + 8'd1;
      end
      default: r_state_nxt = R_IDLE;
    endcase

    // Write start picks its bank against the post-update read lock and latest bank.
    if (wr_frame_start) begin
      wr_begin_nxt = 1'b1;
      if (w_state == W_IDLE || wr_frame_done) begin
        wr_bank_nxt = free_bank(rd_bank_nxt, lat_bank_nxt, lat_valid_nxt);
        wr_addr_nxt = bank_addr(wr_bank_nxt);
        w_state_nxt = W_ACTIVE;
      end else if (wr_abort_cnt != 8'hFF) begin
        abort_nxt = wr_abort_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      r_state       <= R_IDLE;
      wr_begin      <= 1'b0;
      rd_begin      <= 1'b0;
      wr_addr_begin <= '0;
      rd_addr_begin <= '0;
      rd_addr_end   <= '0;
      wr_bank       <= 2'd0;
      rd_bank       <= 2'd0;
      lat_bank      <= 2'd0;
      lat_valid     <= 1'b0;
      wr_abort_cnt  <= 8'd0;
      rd_miss_cnt   <= 8'd0;
    end else begin
      w_state       <= w_state_nxt;
      r_state       <= r_state_nxt;
      wr_begin      <= wr_begin_nxt;
      rd_begin      <= rd_begin_nxt;
      wr_addr_begin <= wr_addr_nxt;
      rd_addr_begin <= rd_addr_b_nxt;
      rd_addr_end   <= rd_addr_e_nxt;
      wr_bank       <= wr_bank_nxt;
      rd_bank       <= rd_bank_nxt;
      lat_bank      <= lat_bank_nxt;
      lat_valid     <= lat_valid_nxt;
      wr_abort_cnt  <= abort_nxt;
      rd_miss_cnt   <= miss_nxt;
    end
  end

endmodule

// File: tb/tb_ddr_frame_bank_ctrl.sv
// Directed bench for ddr_frame_bank_ctrl with hand-computed expected values.
module tb_ddr_frame_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_frame_start, wr_frame_done, rd_frame_req, rd_data_busy;
  logic        wr_begin, rd_begin, lat_valid;
  logic [31:0] wr_addr_begin, rd_addr_begin, rd_addr_end;
  logic [1:0]  wr_bank, rd_bank, lat_bank;
  logic [7:0]  wr_abort_cnt, rd_miss_cnt;

  int checks = 0;
  int errors = 0;

  ddr_frame_bank_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_frame_start(wr_frame_start),
    .wr_frame_done (wr_frame_done),
    .rd_frame_req  (rd_frame_req),
    .rd_data_busy  (rd_data_busy),
    .wr_begin      (wr_begin),
    .wr_addr_begin (wr_addr_begin),
    .rd_begin      (rd_begin),
    .rd_addr_begin (rd_addr_begin),
    .rd_addr_end   (rd_addr_end),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .lat_bank      (lat_bank),
    .lat_valid     (lat_valid),
    .wr_abort_cnt  (wr_abort_cnt),
    .rd_miss_cnt   (rd_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_begin"}, {31'd0, wr_begin}, 32'd0);
    chk({tag, "_rd_begin"}, {31'd0, rd_begin}, 32'd0);
    chk({tag, "_wr_addr"}, wr_addr_begin, 32'd0);
    chk({tag, "_rd_addr_b"}, rd_addr_begin, 32'd0);
    chk({tag, "_rd_addr_e"}, rd_addr_end, 32'd0);
    chk({tag, "_banks"}, {26'd0, wr_bank, rd_bank, lat_bank}, 32'd0);
    chk({tag, "_lat_valid"}, {31'd0, lat_valid}, 32'd0);
    chk({tag, "_cnts"}, {16'd0, wr_abort_cnt, rd_miss_cnt}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_frame_start = 1'b0; wr_frame_done = 1'b0;
    rd_frame_req = 1'b0;   rd_data_busy = 1'b0;
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Read before any frame exists is a miss.
    rd_frame_req = 1'b1; step(); rd_frame_req = 1'b0;
    chk("miss_rd_begin", {31'd0, rd_begin}, 32'd0);
    chk("miss_cnt1", {24'd0, rd_miss_cnt}, 32'd1);

    // First frame: rd_bank=0 excluded, lands in bank 1.
    wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
    chk("w1_begin", {31'd0, wr_begin}, 32'd1);
    chk("w1_addr", wr_addr_begin, 32'h0004_B000);
    chk("w1_bank", {30'd0, wr_bank}, 32'd1);
    step();
    chk("w1_begin_off", {31'd0, wr_begin}, 32'd0);
    wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
    chk("w1_lat", {29'd0, lat_valid, lat_bank}, {29'd0, 1'b1, 2'd1});

    // Lock bank 1 for reading.
    rd_frame_req = 1'b1; step(); rd_frame_req = 1'b0;
    chk("r1_begin", {31'd0, rd_begin}, 32'd1);
    chk("r1_addr_b", rd_addr_begin, 32'h0004_B000);
    chk("r1_addr_e", rd_addr_end, 32'h0009_5FFF);
    chk("r1_bank", {30'd0, rd_bank}, 32'd1);
    step();
    chk("r1_begin_off", {31'd0, rd_begin}, 32'd0);
    rd_data_busy = 1'b1; step();
    rd_frame_req = 1'b1; step(); rd_frame_req = 1'b0;
    chk("busy_req_ignored", {31'd0, rd_begin}, 32'd0);
    chk("miss_cnt2", {24'd0, rd_miss_cnt}, 32'd2);
    rd_data_busy = 1'b0; step();

    // Two frames with bank 1 locked: banks 0 then 2.
    wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
    chk("w2_bank", {30'd0, wr_bank}, 32'd0);
    chk("w2_addr", wr_addr_begin, 32'h0000_0000);
    wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
    wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
    chk("w3_bank", {30'd0, wr_bank}, 32'd2);
    chk("w3_addr", wr_addr_begin, 32'h0009_6000);
    wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
    chk("w3_lat", {30'd0, lat_bank}, 32'd2);

    // Back in R_IDLE: this read locks bank 2.
    rd_frame_req = 1'b1; step(); rd_frame_req = 1'b0;
    chk("r2_begin", {31'd0, rd_begin}, 32'd1);
    chk("r2_addr_b", rd_addr_begin, 32'h0009_6000);
    chk("r2_addr_e", rd_addr_end, 32'h000E_0FFF);
    rd_data_busy = 1'b1; step(); rd_data_busy = 1'b0; step();

    // Re-read of the same bank is allowed.
    rd_frame_req = 1'b1; step(); rd_frame_req = 1'b0;
    chk("r3_begin", {31'd0, rd_begin}, 32'd1);
    chk("r3_bank", {30'd0, rd_bank}, 32'd2);
    chk("miss_cnt_kept", {24'd0, rd_miss_cnt}, 32'd2);
    rd_data_busy = 1'b1; step(); rd_data_busy = 1'b0; step();

    // rd=2, lat=2: start picks bank 0, then aborts.
    wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
    chk("w4_bank", {30'd0, wr_bank}, 32'd0);
    step();
    wr_frame_start = 1'b1; step();
    chk("abort1_begin", {31'd0, wr_begin}, 32'd1);
    chk("abort1_addr", wr_addr_begin, 32'h0000_0000);
    chk("abort1_bank", {30'd0, wr_bank}, 32'd0);
    chk("abort1_cnt", {24'd0, wr_abort_cnt}, 32'd1);
    for (int i = 0; i < 299; i++) step();
    wr_frame_start = 1'b0;
    chk("abort_sat", {24'd0, wr_abort_cnt}, 32'd255);
    step();
    chk("abort_begin_off", {31'd0, wr_begin}, 32'd0);
    wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
    chk("w4_lat", {30'd0, lat_bank}, 32'd0);

    // rd=2, lat=0: next frame in bank 1; done and read in the same cycle.
    wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
    chk("w5_bank", {30'd0, wr_bank}, 32'd1);
    wr_frame_done = 1'b1; rd_frame_req = 1'b1; step();
    wr_frame_done = 1'b0; rd_frame_req = 1'b0;
    chk("bypass_rd_begin", {31'd0, rd_begin}, 32'd1);
    chk("bypass_rd_bank", {30'd0, rd_bank}, 32'd1);
    chk("bypass_rd_addr", rd_addr_begin, 32'h0004_B000);

    // rd=1, lat=1: start -> bank 0; then done+start -> lat 0, new bank 2.
    wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
    chk("w6_bank", {30'd0, wr_bank}, 32'd0);
    step();
    wr_frame_start = 1'b1; wr_frame_done = 1'b1; step();
    wr_frame_start = 1'b0; wr_frame_done = 1'b0;
    chk("donestart_lat", {29'd0, lat_valid, lat_bank}, {29'd0, 1'b1, 2'd0});
    chk("donestart_bank", {30'd0, wr_bank}, 32'd2);
    chk("donestart_begin", {31'd0, wr_begin}, 32'd1);
    chk("donestart_addr", wr_addr_begin, 32'h0009_6000);

    // Asynchronous reset mid-frame and mid-cycle.
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #10 rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
